// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM encoding and SPI mode codes.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_e;

    // Mode codes are {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: pulses tick_o every HALF enabled cycles.
module spi_clk_gen #(
    parameter int HALF = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == CW'(HALF - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || !en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// SPI master, one DATA_W-bit word per start request, mode selectable per transfer.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              spi_clk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam int H  = CLK_DIV / 2;
    localparam int NE = 2 * DATA_W;
    localparam int BW = $clog2(NE + 1);

    state_e            state_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [BW-1:0]     edge_q;
    logic              spi_clk_q;
    logic              cs_q;
    logic              mosi_q;
    logic              busy_q;
    logic              done_q;

    logic tick;
    logic accept;
    logic leading;
    logic last;
    logic do_shift;

    assign accept   = (state_q == ST_IDLE) && start;
    assign leading  = ~edge_q[0];
    assign last     = (edge_q == BW'(NE - 1));
    assign do_shift = mode_q[0] ? leading : (!leading && !last);

    spi_clk_gen #(
        .HALF(H)
    ) u_clk_gen (
        .clk_i (clk),
        .rst_i (reset),
        .clr_i (accept),
        .en_i  (state_q != ST_IDLE),
        .tick_o(tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            edge_q    <= '0;
            spi_clk_q <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    mode_q    <= mode;
                    spi_clk_q <= mode[1];
                    cs_q      <= 1'b1;
                    mosi_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    if (start) begin
                        tx_q    <= tx_data;
                        edge_q  <= '0;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                        // CPHA=1 presents the MSB on the first leading edge instead
                        mosi_q  <= mode[0] ? 1'b1 : tx_data[DATA_W-1];
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        spi_clk_q <= ~spi_clk_q;
                        edge_q    <= edge_q + BW'(1);
                        if (leading ^ mode_q[0]) begin
                            rx_q <= {rx_q[DATA_W-2:0], miso};
                        end
                        if (do_shift) begin
                            mosi_q <= mode_q[0] ? tx_q[DATA_W-1]
                                                : tx_q[DATA_W-2];
                            tx_q   <= tx_q << 1;
                        end
                        if (last) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state_q   <= ST_DONE;
                        spi_clk_q <= mode_q[1];
                        cs_q      <= 1'b1;
                        mosi_q    <= 1'b1;
                        done_q    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data = rx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign spi_clk = spi_clk_q;
    assign cs      = cs_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Scoreboard bench for spi_master_cfg: 8-bit/div-4 and 16-bit/div-2 instances.
module tb_spi_master_cfg;
    import spi_pkg::*;

    typedef struct {
        logic [31:0] rx;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: DATA_W=8, CLK_DIV=4
    logic       start_a;
    logic [1:0] mode_a;
    logic [7:0] tx_a;
    logic [7:0] rx_a;
    logic       busy_a, done_a, sck_a, cs_a, mosi_a, miso_a;
    logic       loop_a;

    // Instance B: DATA_W=16, CLK_DIV=2
    logic        start_b;
    logic [1:0]  mode_b;
    logic [15:0] tx_b;
    logic [15:0] rx_b;
    logic        busy_b, done_b, sck_b, cs_b, mosi_b, miso_b;

    // Slave model for instance A
    logic [7:0] s_word, s_sr, s_rx;
    logic [1:0] s_mode;
    logic       s_miso;

    assign miso_a = loop_a ? mosi_a : s_miso;
    assign miso_b = mosi_b;

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
        .tx_data(tx_a), .rx_data(rx_a), .busy(busy_a), .done(done_a),
        .spi_clk(sck_a), .cs(cs_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_master_cfg #(.DATA_W(16), .CLK_DIV(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
        .tx_data(tx_b), .rx_data(rx_b), .busy(busy_b), .done(done_b),
        .spi_clk(sck_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge cs_a) begin
        s_sr   = s_word;
        s_rx   = '0;
        s_miso = 1'b0;
        if (!s_mode[0]) begin
            s_miso = s_sr[7];
            s_sr   = s_sr << 1;
        end
    end

    always @(sck_a) begin
        if (!cs_a) begin
            if ((sck_a != s_mode[1]) == s_mode[0]) begin
                s_miso = s_sr[7];
                s_sr   = s_sr << 1;
            end else begin
                s_rx = {s_rx[6:0], mosi_a};
            end
        end
    end

    int rises = 0;
    always @(posedge sck_a) if (!cs_a) rises++;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always @(negedge clk) begin
        if (done_a) begin
            if (qa.size() == 0) begin
                check("a_unexpected_done", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                check("a_rx", 32'(rx_a), ea.rx);
                check("a_latency", 32'(cyc), 32'(ea.cyc));
            end
        end
        if (done_b) begin
            if (qb.size() == 0) begin
                check("b_unexpected_done", 32'd1, 32'd0);
            end else begin
                eb = qb.pop_front();
                check("b_rx", 32'(rx_b), eb.rx);
                check("b_latency", 32'(cyc), 32'(eb.cyc));
            end
        end
    end

    task automatic wait_idle_a(input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy_a) break;
        end
        if (k == 100) check(name, 32'd1, 32'd0);
    endtask

    task automatic run_a(input logic [1:0] m, input logic [7:0] tx,
                         input logic [7:0] exp_rx, input int glitch);
        @(negedge clk);
        mode_a  = m;
        tx_a    = tx;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        qa.push_back('{32'(exp_rx), cyc + 36});
        if (glitch > 0) begin
            repeat (glitch - 1) @(negedge clk);
            start_a = 1'b1;
            tx_a    = 8'hFF;
            mode_a  = ~m;
            @(negedge clk);
            start_a = 1'b0;
            tx_a    = tx;
            mode_a  = m;
        end
        wait_idle_a("a_timeout");
        repeat (3) @(negedge clk);
        check("a_rx_hold", 32'(rx_a), 32'(exp_rx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        reset   = 1'b1;
        start_a = 1'b0;
        mode_a  = MODE0;
        tx_a    = '0;
        loop_a  = 1'b1;
        s_word  = '0;
        s_mode  = MODE0;
        start_b = 1'b0;
        mode_b  = MODE0;
        tx_b    = '0;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs_a), 32'd1);
        check("rst_mosi", 32'(mosi_a), 32'd1);
        check("rst_sck", 32'(sck_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_rx", 32'(rx_a), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Mode 0 loopback
        rises = 0;
        run_a(MODE0, 8'hA5, 8'hA5, 0);
        check("m0_rises", 32'(rises), 32'd8);

        // Mode 3 against the slave model
        loop_a = 1'b0;
        s_mode = MODE3;
        s_word = 8'h3C;
        mode_a = MODE3;
        repeat (2) @(negedge clk);
        check("m3_idle_before", 32'(sck_a), 32'd1);
        run_a(MODE3, 8'h81, 8'h3C, 0);
        check("m3_slave_rx", 32'(s_rx), 32'h81);
        check("m3_idle_after", 32'(sck_a), 32'd1);
        loop_a = 1'b1;

        // Restart pulse with new data mid-transfer is ignored
        run_a(MODE0, 8'h3A, 8'h3A, 10);

        // Reset mid-transfer in mode 1
        @(negedge clk);
        mode_a  = MODE1;
        tx_a    = 8'hC7;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (14) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_cs", 32'(cs_a), 32'd1);
        check("mid_rst_sck", 32'(sck_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_rx", 32'(rx_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_a(MODE1, 8'h5A, 8'h5A, 0);

        // Mode 2 with start held high: back-to-back transfers
        @(negedge clk);
        mode_a  = MODE2;
        tx_a    = 8'h96;
        start_a = 1'b1;
        @(negedge clk);
        qa.push_back('{32'h96, cyc + 36});
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done_a) break;
        end
        if (k == 100) check("b2b_timeout", 32'd1, 32'd0);
        tx_a = 8'h69;
        @(negedge clk);
        check("b2b_idle_cs", 32'(cs_a), 32'd1);
        @(negedge clk);
        check("b2b_cs_fall", 32'(cs_a), 32'd0);
        qa.push_back('{32'h69, cyc + 36});
        start_a = 1'b0;
        wait_idle_a("b2b_timeout2");
        repeat (2) @(negedge clk);

        // 16-bit word, CLK_DIV=2, loopback
        tx_b    = 16'hC3E1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        qb.push_back('{32'hC3E1, cyc + 34});
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy_b) break;
        end
        if (k == 100) check("b_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);

        check("a_queue_empty", 32'(qa.size()), 32'd0);
        check("b_queue_empty", 32'(qb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_cfg.md
SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning bits per transfer; legal range 4..32.
REQ-002 The module SHALL have parameter CLK_DIV, default 4, meaning clk cycles per spi_clk period; even, >= 2; H = CLK_DIV/2 is the half-period.
REQ-003 The module SHALL have port clk, input, 1 bit: the system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: transfer request, sampled only in IDLE.
REQ-006 The module SHALL have port mode, input, 2 bits: {CPOL, CPHA}, latched when start is accepted.
REQ-007 The module SHALL have port tx_data, input, DATA_W bits: word to send, latched when start is accepted.
REQ-008 The module SHALL have port rx_data, output, DATA_W bits: word received, valid from done onward.
REQ-009 The module SHALL have port busy, output, 1 bit: high from start acceptance through the done cycle.
REQ-010 The module SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-011 The module SHALL have port spi_clk, output, 1 bit: serial clock.
REQ-012 The module SHALL have port cs, output, 1 bit: active-low chip select.
REQ-013 The module SHALL have port mosi, output, 1 bit: serial data out, MSB first.
REQ-014 The module SHALL have port miso, input, 1 bit: serial data in, MSB first.

Function
REQ-015 The module SHALL implement the states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-016 In IDLE, cs SHALL be 1, mosi SHALL be 1, and spi_clk SHALL equal the registered mode[1], updated every cycle.
REQ-017 In IDLE, start=1 SHALL latch tx_data and mode, set busy, drive cs=0, and enter SETUP on the next cycle.
REQ-018 SETUP SHALL last H cycles with spi_clk held at CPOL; if CPHA=0, mosi SHALL present tx_data[DATA_W-1] throughout SETUP.
REQ-019 SHIFT SHALL produce exactly 2*DATA_W spi_clk edges, one every H cycles, starting with a leading edge (away from CPOL), and SHALL end with spi_clk at CPOL.
REQ-020 With CPHA=0, miso SHALL be sampled on each leading edge, and mosi SHALL advance to the next bit on each trailing edge except the last.
REQ-021 With CPHA=1, mosi SHALL advance on each leading edge (first edge presents the MSB), and miso SHALL be sampled on each trailing edge.
REQ-022 Sampled bits SHALL shift into rx_data LSB-side, so the first bit received ends at rx_data[DATA_W-1].
REQ-023 HOLD SHALL last H cycles with cs=0; cs SHALL rise on entry to DONE.
REQ-024 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE.
REQ-025 The latency from the start-accept edge to the done=1 cycle SHALL be (2*DATA_W+2)*H cycles.
REQ-026 start SHALL be ignored in every state other than IDLE; a start held high in the DONE cycle SHALL be accepted on the following IDLE cycle.
REQ-027 Changes to mode or tx_data while busy=1 SHALL have no effect on the transfer in progress.
REQ-028 rx_data SHALL hold its value until the next transfer's first sample.

Reset
REQ-029 Asserting reset at any time, including mid-transfer, SHALL immediately force state=IDLE, cs=1, mosi=1, spi_clk=0, busy=0, done=0, rx_data=0, latched mode=0, and the divider count=0.
REQ-030 After reset deasserts, the first transfer SHALL behave identically to a transfer from power-up.

Structure
REQ-031 A shared package spi_pkg SHALL hold the state encoding and the mode constants MODE0..MODE3.
REQ-032 A sub-module spi_clk_gen SHALL provide the H-cycle half-period tick; it SHALL be cleared on start acceptance and on reset.
REQ-033 The top level SHALL contain the FSM, the bit counter (width clog2(2*DATA_W+1)), and the tx/rx shift registers.

Verification
REQ-034 Mode 0, DATA_W=8, CLK_DIV=4, tx_data=0xA5, miso looped to mosi -> rx_data=0xA5, done exactly 36 cycles after start, and 8 rising spi_clk edges with cs low.
REQ-035 Mode 3, slave model returning 0x3C, tx_data=0x81 -> slave receives 0x81, rx_data=0x3C, idle spi_clk=1 before and after the transfer.
REQ-036 Pulse start again at cycle 10 of a transfer, with tx_data changed to 0xFF -> the pulse is ignored, the original word is sent, and done occurs once.
REQ-037 Assert reset at cycle 15 of a mode 1 transfer -> cs=1, spi_clk=0, and busy=0 immediately; a following 0x5A transfer completes correctly.
REQ-038 Hold start high continuously in mode 2 -> back-to-back transfers with exactly one IDLE cycle between the done pulse and the next cs fall.
REQ-039 DATA_W=16, CLK_DIV=2, tx_data=0xC3E1, loopback -> rx_data=0xC3E1, done 34 cycles after start.
